// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: opcodes, funct3 width codes, FSM states.
// Latency: n/a (constants and one pure helper function).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam logic [6:0]  LOAD     = 7'b0000011;
  localparam logic [6:0]  STORE    = 7'b0100011;
  localparam logic [6:0]  ALOPI    = 7'b0010011;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Bytes moved by an access; any undefined width code is a full word.
  function automatic logic [2:0] byte_count(input logic [2:0] f3);
    logic [2:0] n;
    case (f3)
      F3_B, F3_BU: n = 3'd1;
      F3_H, F3_HU: n = 3'd2;
      default:     n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of the assembled load buffer according to funct3.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] ext_o
);

  // Pick the extension rule; undefined codes pass the full word like LW.
  always_comb begin
    ext_o = data_i;
    case (funct3_i)
      F3_B:    ext_o = {{24{data_i[7]}}, data_i[7:0]};
      F3_H:    ext_o = {{16{data_i[15]}}, data_i[15:0]};
      F3_BU:   ext_o = {24'h000000, data_i[7:0]};
      F3_HU:   ext_o = {16'h0000, data_i[15:0]};
      default: ext_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: serialises loads/stores into little-endian byte accesses, passes others through.
// Latency: non-memory 0 cycles; memory op with zero-wait acks stalls N+1 cycles, result in cycle N+2.
// Backpressure: stall_req holds upstream; rdy_in=0 freezes all state and ignores mem_ack.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [4:0]            rd_addr,
  input  logic [31:0]           rd_val,
  input  logic [6:0]            ins_type,
  input  logic [2:0]            funct3,
  input  logic [31:0]           st_val,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ack,
  output logic                  stall_req,
  output logic [4:0]            output_rd_addr,
  output logic [31:0]           output_rd_val,
  output logic [6:0]            output_ins_type
);

  state_e      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] data_q, data_d;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic [2:0]  n_bytes;
  logic        last_byte;
  logic [31:0] ext_val;

  assign is_load   = (ins_type == LOAD);
  assign is_store  = (ins_type == STORE);
  assign is_mem    = is_load | is_store;
  assign n_bytes   = byte_count(funct3);
  assign last_byte = ({1'b0, byte_idx_q} == (n_bytes - 3'd1));

  // Address wraps modulo 2^ADDR_WIDTH, so misaligned or top-of-memory accesses need no special case.
  assign mem_addr  = ADDR_WIDTH'(rd_val) + ADDR_WIDTH'(byte_idx_q);
  assign mem_wdata = st_val[{byte_idx_q, 3'b000} +: 8];

  load_extend u_load_extend (
    .data_i   (data_q),
    .funct3_i (funct3),
    .ext_o    (ext_val)
  );

  // Next state: start on a memory op, step bytes on ack, retire after the last byte.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    data_d     = data_q;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          state_d    = ACCESS;
          byte_idx_d = 2'd0;
          data_d     = ZeroWord;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          if (is_load) begin
            data_d[{byte_idx_q, 3'b000} +: 8] = mem_rdata;
          end
          if (last_byte) begin
            state_d = DONE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        byte_idx_d = 2'd0;
      end
      default: begin
        state_d    = IDLE;
        byte_idx_d = 2'd0;
      end
    endcase
  end

  // State register; rdy_in low freezes everything, which also drops any ack in that cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      byte_idx_q <= 2'd0;
      data_q     <= ZeroWord;
    end else if (rdy_in) begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      data_q     <= data_d;
    end
  end

  // Outputs: bubble by default; reset gates them so they drop the instant rst_in rises.
  always_comb begin
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    stall_req       = 1'b0;
    output_rd_addr  = 5'd0;
    output_rd_val   = ZeroWord;
    output_ins_type = ALOPI;
    if (!rst_in) begin
      case (state_q)
        IDLE: begin
          if (is_mem) begin
            stall_req = 1'b1;
          end else begin
            output_rd_addr  = rd_addr;
            output_rd_val   = rd_val;
            output_ins_type = ins_type;
          end
        end
        ACCESS: begin
          mem_req   = 1'b1;
          mem_we    = is_store;
          stall_req = 1'b1;
        end
        DONE: begin
          if (is_store) begin
            output_ins_type = STORE;
          end else begin
            output_rd_addr  = rd_addr;
            output_rd_val   = ext_val;
            output_ins_type = ins_type;
          end
        end
        default: begin
          stall_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: acts as a byte-wide memory with random wait states and checks every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALOPI = 7'b0010011;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [4:0]  rd_addr;
  logic [31:0] rd_val;
  logic [6:0]  ins_type;
  logic [2:0]  funct3;
  logic [31:0] st_val;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        stall_req;
  logic [4:0]  output_rd_addr;
  logic [31:0] output_rd_val;
  logic [6:0]  output_ins_type;

  int checks   = 0;
  int failures = 0;

  // Reference byte memory; unseen locations get random content on first touch.
  logic [7:0] mem_m [logic [31:0]];

  mem_stage #(.ADDR_WIDTH(32)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .rd_addr         (rd_addr),
    .rd_val          (rd_val),
    .ins_type        (ins_type),
    .funct3          (funct3),
    .st_val          (st_val),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack),
    .stall_req       (stall_req),
    .output_rd_addr  (output_rd_addr),
    .output_rd_val   (output_rd_val),
    .output_ins_type (output_ins_type)
  );

  initial forever #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    if (!mem_m.exists(a)) mem_m[a] = 8'($urandom);
    return mem_m[a];
  endfunction

  // Little-endian assembly followed by arithmetic sign extension for LB/LH.
  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < nbytes(f3); i++) v = v + (32'(get_byte(a + 32'(i))) << (8 * i));
    if (f3 == 3'b000 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
    if (f3 == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  // Present one memory op, act as the controller with waits in [wmin,wmax], optionally
  // drop rdy_in during one ack (hold_byte), and check every cycle until retirement.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] sval,
                        input int wmin, input int wmax, input int hold_byte,
                        output logic [31:0] got, output int stalls);
    int n, k, wcur, totw;
    bit done, held, st;
    logic [31:0] exp_v;
    ins_type = op; funct3 = f3; rd_addr = rd; rd_val = addr; st_val = sval;
    n = nbytes(f3); st = (op == OP_STORE);
    k = 0; stalls = 0; done = 0; held = 0; got = 32'd0;
    wcur = int'($urandom_range(wmax, wmin)); totw = wcur;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk_in);
      rdy_in = 1'b1; mem_ack = 1'b0;
      if (stall_req === 1'b1) begin
        stalls++;
        checks++;
        if (output_ins_type !== OP_ALOPI || output_rd_addr !== 5'd0 || output_rd_val !== 32'd0) begin
          failures++;
          $display("FAIL stall_bubble: got ins=%h rd=%0d val=%h, need ins=%h rd=0 val=0",
                   output_ins_type, output_rd_addr, output_rd_val, OP_ALOPI);
        end
        if (mem_req === 1'b1) begin
          checks++;
          if (mem_addr !== addr + 32'(k) || mem_we !== st) begin
            failures++;
            $display("FAIL byte_addr: got addr=%h we=%b, need addr=%h we=%b",
                     mem_addr, mem_we, addr + 32'(k), st);
          end
          if (st) begin
            checks++;
            if (mem_wdata !== 8'(sval >> (8 * k))) begin
              failures++;
              $display("FAIL store_byte: got %h, need %h", mem_wdata, 8'(sval >> (8 * k)));
            end
          end
          if (wcur > 0) begin
            wcur--;
          end else if (hold_byte == k && !held) begin
            held = 1; rdy_in = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hEE; totw++;
          end else begin
            mem_ack = 1'b1;
            if (st) mem_m[addr + 32'(k)] = 8'(sval >> (8 * k));
            else    mem_rdata = get_byte(addr + 32'(k));
            k++;
            if (k < n) begin
              wcur = int'($urandom_range(wmax, wmin)); totw += wcur;
            end
          end
        end else begin
          checks++;
          if (stalls != 1) begin
            failures++;
            $display("FAIL req_held: mem_req dropped mid-access at stall cycle %0d, need 1", stalls);
          end
        end
      end else begin
        done = 1;
        got = output_rd_val;
        exp_v = st ? 32'd0 : exp_load(addr, f3);
        checks++;
        if (mem_req !== 1'b0 || output_ins_type !== op ||
            output_rd_addr !== (st ? 5'd0 : rd) || output_rd_val !== exp_v) begin
          failures++;
          $display("FAIL retire: got req=%b ins=%h rd=%0d val=%h, need req=0 ins=%h rd=%0d val=%h",
                   mem_req, output_ins_type, output_rd_addr, output_rd_val,
                   op, (st ? 5'd0 : rd), exp_v);
        end
        checks++;
        if (stalls != n + 1 + totw) begin
          failures++;
          $display("FAIL stall_len: got %0d cycles, need %0d", stalls, n + 1 + totw);
        end
      end
      @(posedge clk_in); #1;
    end
    mem_ack = 1'b0;
    if (!done) begin
      failures++;
      $display("FAIL op_timeout: no retirement within 200 cycles, need retirement");
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b1; rdy_in = 1'b1; ins_type = OP_LOAD; funct3 = 3'b010;
    rd_addr = 5'd4; rd_val = 32'h40; st_val = 32'd0; mem_ack = 1'b0; mem_rdata = 8'd0;
    #2;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got req=%b we=%b stall=%b, need 0 0 0", mem_req, mem_we, stall_req);
    end
    @(posedge clk_in); #1; @(posedge clk_in); #1;
    checks++;
    if (output_ins_type !== OP_ALOPI || output_rd_addr !== 5'd0 || output_rd_val !== 32'd0 ||
        stall_req !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_bubble: got ins=%h rd=%0d val=%h stall=%b req=%b, need bubble",
               output_ins_type, output_rd_addr, output_rd_val, stall_req, mem_req);
    end
    ins_type = OP_ALOPI;
    rst_in = 1'b0;
  endtask

  task automatic test_passthrough(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] v);
    ins_type = op; rd_addr = rd; rd_val = v; funct3 = 3'($urandom); st_val = $urandom;
    @(negedge clk_in);
    checks++;
    if (stall_req !== 1'b0 || mem_req !== 1'b0 || output_ins_type !== op ||
        output_rd_addr !== rd || output_rd_val !== v) begin
      failures++;
      $display("FAIL passthrough: got stall=%b req=%b ins=%h rd=%0d val=%h, need 0 0 %h %0d %h",
               stall_req, mem_req, output_ins_type, output_rd_addr, output_rd_val, op, rd, v);
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_lw;
    logic [31:0] got; int stalls;
    mem_m[32'h100] = 8'h78; mem_m[32'h101] = 8'h56; mem_m[32'h102] = 8'h34; mem_m[32'h103] = 8'h12;
    run_op(OP_LOAD, 3'b010, 5'd3, 32'h100, 32'd0, 0, 0, -1, got, stalls);
    checks++;
    if (got !== 32'h1234_5678 || stalls != 5) begin
      failures++;
      $display("FAIL lw_direct: got val=%h stalls=%0d, need 12345678 and 5", got, stalls);
    end
  endtask

  task automatic test_lb_lbu;
    logic [31:0] got; int stalls;
    mem_m[32'h203] = 8'h80;
    run_op(OP_LOAD, 3'b000, 5'd6, 32'h203, 32'd0, 0, 1, -1, got, stalls);
    checks++;
    if (got !== 32'hFFFF_FF80) begin
      failures++;
      $display("FAIL lb_sign: got %h, need ffffff80", got);
    end
    run_op(OP_LOAD, 3'b100, 5'd6, 32'h203, 32'd0, 0, 1, -1, got, stalls);
    checks++;
    if (got !== 32'h0000_0080) begin
      failures++;
      $display("FAIL lbu_zero: got %h, need 00000080", got);
    end
  endtask

  task automatic test_lh;
    logic [31:0] got; int stalls;
    mem_m[32'h50] = 8'h01; mem_m[32'h51] = 8'h80;
    run_op(OP_LOAD, 3'b001, 5'd8, 32'h50, 32'd0, 0, 0, -1, got, stalls);
    checks++;
    if (got !== 32'hFFFF_8001) begin
      failures++;
      $display("FAIL lh_sign: got %h, need ffff8001", got);
    end
  endtask

  task automatic test_sh;
    logic [31:0] got; int stalls;
    run_op(OP_STORE, 3'b001, 5'd9, 32'h10, 32'hAABB_CCDD, 3, 3, -1, got, stalls);
    checks++;
    if (stalls != 9) begin
      failures++;
      $display("FAIL sh_waits: got %0d stall cycles, need 9", stalls);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] got; int stalls;
    ins_type = OP_LOAD; funct3 = 3'b010; rd_addr = 5'd7; rd_val = 32'h300; st_val = 32'd0;
    @(negedge clk_in); mem_ack = 1'b0;
    @(negedge clk_in); mem_ack = 1'b1; mem_rdata = get_byte(32'h300);
    @(negedge clk_in); mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h301) begin
      failures++;
      $display("FAIL pre_reset_byte1: got req=%b addr=%h, need 1 00000301", mem_req, mem_addr);
    end
    rst_in = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall_req !== 1'b0 || mem_we !== 1'b0 ||
        output_ins_type !== OP_ALOPI || output_rd_val !== 32'd0 || output_rd_addr !== 5'd0) begin
      failures++;
      $display("FAIL async_reset: got req=%b stall=%b ins=%h val=%h, need 0 0 %h 0",
               mem_req, stall_req, output_ins_type, output_rd_val, OP_ALOPI);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    run_op(OP_LOAD, 3'b010, 5'd7, 32'h300, 32'd0, 0, 1, -1, got, stalls);
  endtask

  task automatic test_rdy_hold;
    logic [31:0] got; int stalls;
    run_op(OP_LOAD, 3'b010, 5'd11, 32'h400, 32'd0, 0, 0, 1, got, stalls);
    run_op(OP_STORE, 3'b010, 5'd12, 32'h410, 32'h1357_9BDF, 0, 1, 2, got, stalls);
  endtask

  task automatic test_back_to_back;
    logic [31:0] got; int stalls;
    run_op(OP_LOAD, 3'b010, 5'd1, 32'h500, 32'd0, 0, 0, -1, got, stalls);
    run_op(OP_STORE, 3'b000, 5'd2, 32'h501, 32'h0000_00A5, 0, 0, -1, got, stalls);
    run_op(OP_LOAD, 3'b101, 5'd3, 32'h500, 32'd0, 0, 0, -1, got, stalls);
    test_passthrough(OP_ALOPI, 5'd4, 32'hCAFE_0001);
  endtask

  task automatic test_wrap;
    logic [31:0] got; int stalls;
    run_op(OP_LOAD, 3'b010, 5'd13, 32'hFFFF_FFFE, 32'd0, 0, 1, -1, got, stalls);
    run_op(OP_STORE, 3'b010, 5'd14, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 1, -1, got, stalls);
    run_op(OP_LOAD, 3'b110, 5'd15, 32'hFFFF_FFFF, 32'd0, 0, 0, -1, got, stalls);
  endtask

  task automatic test_random;
    logic [31:0] got; int stalls;
    logic [6:0] op; logic [2:0] f3; logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(3, 0) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(3, 0));
      case ($urandom_range(2, 0))
        0: begin
          op = 7'($urandom);
          if (op == OP_LOAD || op == OP_STORE) op = 7'b0110011;
          test_passthrough(op, 5'($urandom), $urandom);
        end
        1: begin
          f3 = 3'($urandom);
          run_op(OP_LOAD, f3, 5'($urandom), a, 32'd0, 0, 2,
                 int'($urandom_range(4, 0)) - 1, got, stalls);
        end
        default: begin
          f3 = 3'($urandom_range(2, 0));
          run_op(OP_STORE, f3, 5'($urandom), a, $urandom, 0, 2,
                 int'($urandom_range(4, 0)) - 1, got, stalls);
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_passthrough(OP_ALOPI, 5'd5, 32'h0000_1234);
    test_lw();
    test_lb_lbu();
    test_lh();
    test_sh();
    test_reset_mid();
    test_rdy_hold();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline. It sits between the EX_MEM register and the MEM_WB register.
- Non-memory instructions pass straight through.
- Loads and stores are broken into little-endian byte transfers on the byte-wide memory-controller port. The stage asserts a stall until the last byte completes.
- On completion it presents the sign- or zero-extended load result, or a store retirement, to MEM_WB.

Parameters:
- ADDR_WIDTH, 32, width of the memory byte address.

Ports:
- clk_in  input  1  system clock; all state updates on posedge.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  global ready; when low, all state holds.
- rd_addr  input  5  destination register from EX_MEM.
- rd_val  input  32  ALU result from EX_MEM; for loads and stores it is the effective address.
- ins_type  input  7  opcode from EX_MEM.
- funct3  input  3  access width and signedness.
- st_val  input  32  store data (rs2 value).
- mem_req  output  1  byte access request to the memory controller.
- mem_we  output  1  1 = write byte, 0 = read byte.
- mem_addr  output  ADDR_WIDTH  byte address = rd_val + byte_idx.
- mem_wdata  output  8  store byte st_val[8*byte_idx +: 8].
- mem_rdata  input  8  read byte; valid only in a mem_ack cycle.
- mem_ack  input  1  one-cycle completion of the current byte.
- stall_req  output  1  to the stall controller: hold IF..EX_MEM and bubble MEM_WB.
- output_rd_addr  output  5  to MEM_WB.
- output_rd_val  output  32  to MEM_WB.
- output_ins_type  output  7  to MEM_WB.

Behaviour:
- Reset is asynchronous and active-high. Asserting rst_in at any time, including mid-access, immediately forces:
  - state=IDLE, byte_idx=0, data buffer=0;
  - mem_req=0, mem_we=0, stall_req=0;
  - outputs = bubble: ALOPI, rd_addr 0, rd_val ZeroWord.
- Opcode decode:
  - LOAD 7'b0000011 and STORE 7'b0100011 are memory operations; all other opcodes are non-memory.
  - funct3 selects width and signedness: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - Byte count N = 1, 2 or 4. An undefined funct3 is treated as a 4-byte access.
- State IDLE:
  - Non-memory instruction: outputs equal the inputs combinationally; stall_req=0.
  - Memory instruction: stall_req=1 combinationally in the same cycle and outputs = bubble. The state goes to ACCESS on the next edge with byte_idx=0; mem_req is not yet asserted.
- State ACCESS:
  - mem_req=1; mem_we=1 for STORE, 0 for LOAD.
  - mem_addr and mem_wdata are derived from the current byte_idx and are stable until mem_ack.
  - stall_req=1 and outputs = bubble.
  - On mem_ack, a load captures mem_rdata into buf[8*byte_idx +: 8].
  - If byte_idx==N-1, the state goes to DONE; otherwise byte_idx increments.
  - The controller may take any number of cycles per byte. mem_req stays high between bytes.
- State DONE:
  - mem_req=0 and stall_req=0.
  - LOAD outputs: rd_addr and ins_type from the inputs (still held by the stall); rd_val = extended buf. Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - STORE outputs: ins_type STORE, rd_addr 0, rd_val 0.
  - The next state is always IDLE, and the pipeline advances this cycle.
- Latency:
  - A memory operation with zero-wait acks holds stall_req for N+1 cycles and delivers its result in cycle N+2.
  - Back-to-back memory operations are legal: IDLE sees the second one and re-asserts stall_req.
- rdy_in=0: no state, byte_idx or buffer update; mem_ack is ignored in that cycle. Combinational outputs continue to reflect the held state.
- Alignment: no misalignment exception is raised, because byte-serial access handles any address. An address wrap at 2^ADDR_WIDTH is modulo.
- Upstream inputs must stay stable while stall_req=1. The block does not re-latch them.

Decomposition:
- Shared defines package:
  - opcodes LOAD, STORE, ALOPI;
  - ZeroWord;
  - funct3 width codes;
  - state encodings IDLE/ACCESS/DONE (2 bits).
- One natural sub-module, load_extend: combinational (buf, funct3) -> 32-bit extended value. The FSM, byte counter and pass-through mux stay in mem_stage.

Test Plan:
- ALOPI with rd_addr=5, rd_val=0x1234 -> outputs mirror the inputs in the same cycle; stall_req=0; mem_req never asserted.
- LW at addr 0x100, acks returning 0x78, 0x56, 0x34, 0x12 with zero wait:
  - mem_addr steps 0x100..0x103;
  - stall_req is high for 5 cycles;
  - the DONE cycle shows rd_val=0x12345678.
- LB then LBU of byte 0x80 at 0x203 -> rd_val 0xFFFFFF80, then 0x00000080.
- LH reading 0x8001 -> rd_val 0xFFFF8001.
- SH st_val=0xAABBCCDD at 0x10, ack delayed 3 cycles per byte:
  - two writes: 0xDD@0x10, then 0xCC@0x11;
  - mem_req held high through the waits;
  - DONE shows STORE with rd_addr 0.
- rst_in pulsed after byte 1 of an LW:
  - mem_req and stall_req drop asynchronously; state=IDLE.
  - The re-presented LW restarts at byte_idx 0.
  - With rdy_in=0 during an ack, the ack is ignored and byte_idx is unchanged.
